mult_seq_control: RTL and testbench

//  Parametrised sequencer for the shift-add multiplier datapath (XA:B register

---
 rtl/mult_seq_control.sv | 147 ++++++++++++++
 tb/tb_mult_seq_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_control.sv
// Sequencer for the shift-add multiplier datapath (XA:B pair, 9-bit adder, X flip-flop).
// Optional build macro MULT_SEQ_CTRL_SKIP_ZERO_EN folds zero-bit steps into a single ADD cycle.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for ClearA_LoadB (priority) or Run
// LOAD      | one-cycle Clr_Ld pulse
// LOAD_HOLD | waiting for ClearA_LoadB release, one load per press
// CLEAR     | clear XA and X, latch Signed, reset step counter
// ADD       | conditional add/subtract of S, decided by M
// SHIFT     | arithmetic right shift of X:XA:B, advance step counter
// HOLD      | result valid, waiting for Run release

module mult_seq_control #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic Signed,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_LOAD_HOLD = 3'd2,
        S_CLEAR     = 3'd3,
        S_ADD       = 3'd4,
        S_SHIFT     = 3'd5,
        S_HOLD      = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sgn_q;
    logic          last;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sgn_q <= 1'b0;
        end else begin
            if (Shift) begin
                cnt <= cnt + CW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (ClearA_LoadB) begin
                        state <= S_LOAD;
                    end else if (Run) begin
                        state <= S_CLEAR;
                    end
                end
                S_LOAD: begin
                    state <= ClearA_LoadB ? S_LOAD_HOLD : S_IDLE;
                end
                S_LOAD_HOLD: begin
                    if (!ClearA_LoadB) begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    sgn_q <= Signed;
                    cnt   <= '0;
                    state <= S_ADD;
                end
                S_ADD: begin
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
                    // A zero multiplier bit shifts in place; only one bits need the adder cycle
                    if (M) begin
                        state <= S_SHIFT;
                    end else if (last) begin
                        state <= S_HOLD;
                    end
`else
                    state <= S_SHIFT;
`endif
                end
                S_SHIFT: begin
                    state <= last ? S_HOLD : S_ADD;
                end
                S_HOLD: begin
                    if (!Run) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from state so that an async reset silences them at once
    always_comb begin
        Clr_Ld = 1'b0;
        Clr_XA = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (state)
            S_LOAD: begin
                Clr_Ld = 1'b1;
            end
            S_CLEAR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            S_ADD: begin
                Busy = 1'b1;
                // The MSB of a two's-complement multiplier carries negative weight
                Sub  = M & sgn_q & last;
                Add  = M & ~(sgn_q & last);
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
                Shift = ~M;
`endif
            end
            S_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            S_HOLD: begin
                Done = 1'b1;
            end
            default: begin
                Done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// Bench for mult_seq_control: WIDTH=8 and WIDTH=16 instances, each fed M by a small B-register model.
// Expected per-cycle strobe traces are queued at start of each multiply and popped as cycles elapse.

module tb_mult_seq_control;

    logic Clk;
    logic Reset_n;
    logic run8, run16;
    logic ClearA_LoadB;
    logic Signed;
    logic m8, m16;
    logic clr_ld8, clr_xa8, add8, sub8, shift8, busy8, done8;
    logic clr_ld16, clr_xa16, add16, sub16, shift16, busy16, done16;
    logic [6:0] o8, o16;

    logic [7:0]  b_init8;
    logic [15:0] b_init16;
    logic [4:0]  nsh8, nsh16;

    int tests;
    int fails;

    mult_seq_control #(.WIDTH(8)) u_dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(run8), .ClearA_LoadB(ClearA_LoadB),
        .Signed(Signed), .M(m8), .Clr_Ld(clr_ld8), .Clr_XA(clr_xa8), .Add(add8),
        .Sub(sub8), .Shift(shift8), .Busy(busy8), .Done(done8)
    );

    mult_seq_control #(.WIDTH(16)) u_dut16 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(run16), .ClearA_LoadB(1'b0),
        .Signed(Signed), .M(m16), .Clr_Ld(clr_ld16), .Clr_XA(clr_xa16), .Add(add16),
        .Sub(sub16), .Shift(shift16), .Busy(busy16), .Done(done16)
    );

    assign o8  = {clr_ld8, clr_xa8, add8, sub8, shift8, busy8, done8};
    assign o16 = {clr_ld16, clr_xa16, add16, sub16, shift16, busy16, done16};

    // B register model: bit nsh is the current LSB after nsh shifts
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nsh8  <= '0;
            nsh16 <= '0;
        end else begin
            if (clr_xa8)       nsh8 <= '0;
            else if (shift8)   nsh8 <= nsh8 + 5'd1;
            if (clr_xa16)      nsh16 <= '0;
            else if (shift16)  nsh16 <= nsh16 + 5'd1;
        end
    end
    assign m8  = (nsh8 < 5'd8) ? b_init8[nsh8[2:0]] : 1'b0;
    assign m16 = (nsh16 < 5'd16) ? b_init16[nsh16[3:0]] : 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}
    localparam logic [6:0] E_CLEAR = 7'b0100010;
    localparam logic [6:0] E_ADD   = 7'b0010010;
    localparam logic [6:0] E_SUB   = 7'b0001010;
    localparam logic [6:0] E_NOP   = 7'b0000010;
    localparam logic [6:0] E_SHIFT = 7'b0000110;
    localparam logic [6:0] E_DONE  = 7'b0000001;

    typedef struct {
        bit          wide;
        logic [15:0] b;
        logic        sgn;
        int          exp_add;
        int          exp_sub;
        int          exp_done_fixed;
        int          exp_done_skip;
    } vec_t;

    vec_t vecs[8];
    logic [6:0] sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic push_expected(input int w, input logic [15:0] b, input logic sgn);
        sb_q.push_back(E_CLEAR);
        for (int i = 0; i < w; i++) begin
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
            if (b[i]) begin
                sb_q.push_back((sgn && i == w - 1) ? E_SUB : E_ADD);
                sb_q.push_back(E_SHIFT);
            end else begin
                sb_q.push_back(E_SHIFT);
            end
`else
            if (b[i]) sb_q.push_back((sgn && i == w - 1) ? E_SUB : E_ADD);
            else      sb_q.push_back(E_NOP);
            sb_q.push_back(E_SHIFT);
`endif
        end
        sb_q.push_back(E_DONE);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int w, cyc, n_add, n_sub, n_shift, done_cyc, exp_done;
        logic [6:0] act, exp;
        v = vecs[idx];
        w = v.wide ? 16 : 8;
        @(negedge Clk);
        b_init8  = v.b[7:0];
        b_init16 = v.b;
        Signed   = v.sgn;
        if (v.wide) run16 = 1'b1;
        else        run8  = 1'b1;
        sb_q.delete();
        push_expected(w, v.b, v.sgn);
        cyc = 0; n_add = 0; n_sub = 0; n_shift = 0; done_cyc = 0;
        while (sb_q.size() > 0 && cyc < 80) begin
            @(posedge Clk);
            #1;
            cyc++;
            act = v.wide ? o16 : o8;
            exp = sb_q.pop_front();
            check7($sformatf("vec%0d cycle%0d strobes", idx, cyc), act, exp);
            if (act[4]) n_add++;
            if (act[3]) n_sub++;
            if (act[2]) n_shift++;
            if (act[0] && done_cyc == 0) done_cyc = cyc;
        end
        check($sformatf("vec%0d scoreboard drained", idx), sb_q.size(), 0);
        check($sformatf("vec%0d add pulses", idx), n_add, v.exp_add);
        check($sformatf("vec%0d sub pulses", idx), n_sub, v.exp_sub);
        check($sformatf("vec%0d shift pulses", idx), n_shift, w);
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
        exp_done = v.exp_done_skip;
`else
        exp_done = v.exp_done_fixed;
`endif
        check($sformatf("vec%0d done cycle", idx), done_cyc, exp_done);
        // Held Run keeps HOLD; no second multiply
        repeat (2) begin
            @(posedge Clk);
            #1;
            check7($sformatf("vec%0d hold with Run", idx), v.wide ? o16 : o8, E_DONE);
        end
        @(negedge Clk);
        run8  = 1'b0;
        run16 = 1'b0;
        @(posedge Clk);
        #1;
        check7($sformatf("vec%0d idle after Run release", idx), v.wide ? o16 : o8, 7'b0);
    endtask

    initial begin
        int n_ld, n_busy;
        tests = 0;
        fails = 0;
        run8 = 1'b0; run16 = 1'b0; ClearA_LoadB = 1'b0; Signed = 1'b0;
        b_init8 = '0; b_init16 = '0;

        //               wide  b         sgn  add sub fixed skip
        vecs[0] = '{1'b0, 16'h00FF, 1'b1, 7,  1,  18, 18};
        vecs[1] = '{1'b0, 16'h00FF, 1'b0, 8,  0,  18, 18};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 0,  0,  18, 10};
        vecs[3] = '{1'b0, 16'h00A5, 1'b1, 3,  1,  18, 14};
        vecs[4] = '{1'b0, 16'h005A, 1'b1, 4,  0,  18, 14};
        vecs[5] = '{1'b0, 16'h0080, 1'b0, 1,  0,  18, 11};
        vecs[6] = '{1'b1, 16'hFFFF, 1'b0, 16, 0,  34, 34};
        vecs[7] = '{1'b1, 16'h8001, 1'b1, 1,  1,  34, 20};

        Reset_n = 1'b0;
        #1;
        check7("reset outputs w8", o8, 7'b0);
        check7("reset outputs w16", o16, 7'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check7("idle after reset w8", o8, 7'b0);
        check7("idle after reset w16", o16, 7'b0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // ClearA_LoadB held 5 cycles with Run high: exactly one load, no multiply
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        run8 = 1'b1;
        n_ld = 0; n_busy = 0;
        repeat (5) begin
            @(posedge Clk);
            #1;
            if (clr_ld8) n_ld++;
            if (busy8)   n_busy++;
        end
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        run8 = 1'b0;
        repeat (3) begin
            @(posedge Clk);
            #1;
            if (clr_ld8) n_ld++;
            if (busy8)   n_busy++;
        end
        check("load pulse count", n_ld, 1);
        check("busy during load", n_busy, 0);
        check7("idle after load", o8, 7'b0);

        // Async reset at cycle 7 of a multiply aborts at once
        @(negedge Clk);
        b_init8 = 8'hFF;
        Signed = 1'b1;
        run8 = 1'b1;
        repeat (7) @(posedge Clk);
        #3;
        check("busy before abort", int'(busy8), 1);
        Reset_n = 1'b0;
        #1;
        check7("outputs on mid-op reset", o8, 7'b0);
        check("cnt cleared by reset", int'(u_dut8.cnt), 0);
        run8 = 1'b0;
        @(posedge Clk);
        #1;
        check7("outputs held in reset", o8, 7'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check7("idle after abort", o8, 7'b0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
